// File: rtl/spi_boot_loader.sv
// SPI flash boot master: issues one READ (0x03), packs bytes into little-endian words, writes memory.
// Optional trailing checksum word and boot_error port are enabled by KMIE_BOOT_CHECKSUM_EN.
module spi_boot_loader #(
   parameter int          CLK_DIV    = 2,
   parameter int          BOOT_WORDS = 1024,
   parameter logic [23:0] FLASH_ADDR = 24'h000000,
   localparam int         AW         = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic          spi_sck,
   output logic          spi_mosi,
   output logic          spi_ss,
   input  logic          spi_miso,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          boot_sequence_done
`ifdef KMIE_BOOT_CHECKSUM_EN
   ,
   output logic          boot_error
`endif
);

`ifdef KMIE_BOOT_CHECKSUM_EN
   localparam int EXTRA_WORDS = 1;
`else
   localparam int EXTRA_WORDS = 0;
`endif
   localparam int TOTAL_WORDS = BOOT_WORDS + EXTRA_WORDS;
   localparam int WCW         = $clog2(TOTAL_WORDS + 1);
   localparam int DW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [AW-1:0]  ADDR_LAST = AW'(BOOT_WORDS - 1);
   localparam logic [WCW-1:0] PAY_WORDS = WCW'(BOOT_WORDS);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(TOTAL_WORDS - 1);
   localparam logic [31:0]    CMD_WORD  = {8'h03, FLASH_ADDR};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state_r;
   logic [DW-1:0]  div_cnt_r;
   logic [4:0]     bit_cnt_r;
   logic [30:0]    cmd_sh_r;
   logic [6:0]     byte_sh_r;
   logic [23:0]    word_r;
   logic [WCW-1:0] word_cnt_r;
   logic           last_r;
   logic           drain_r;
`ifdef KMIE_BOOT_CHECKSUM_EN
   logic [31:0]    sum_r;
   logic [31:0]    chk_r;
`endif

   logic           sck_edge_s;
   logic [7:0]     byte_next_s;
   logic [31:0]    word_full_s;

   // SCK phase boundary, byte being completed by the current MISO sample, and the full word.
   assign sck_edge_s  = (div_cnt_r == DIV_LAST);
   assign byte_next_s = {byte_sh_r, spi_miso};
   assign word_full_s = {byte_next_s, word_r};

   // Boot sequencer: SCK generation, command shift-out, data capture and memory writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r            <= IDLE;
         div_cnt_r          <= '0;
         bit_cnt_r          <= 5'd0;
         cmd_sh_r           <= 31'd0;
         byte_sh_r          <= 7'd0;
         word_r             <= 24'd0;
         word_cnt_r         <= '0;
         last_r             <= 1'b0;
         drain_r            <= 1'b0;
         spi_sck            <= 1'b0;
         spi_mosi           <= 1'b0;
         spi_ss             <= 1'b1;
         mem_we             <= 1'b0;
         mem_addr           <= '0;
         mem_wdata          <= 32'd0;
         boot_sequence_done <= 1'b0;
`ifdef KMIE_BOOT_CHECKSUM_EN
         sum_r              <= 32'd0;
         chk_r              <= 32'd0;
         boot_error         <= 1'b0;
`endif
      end else begin
         if (mem_we) begin
            mem_we <= 1'b0;
            if (mem_addr != ADDR_LAST) begin
               mem_addr <= mem_addr + 1'b1;
            end
         end
         case (state_r)
            IDLE: begin
               state_r   <= CMD;
               spi_ss    <= 1'b0;
               spi_mosi  <= CMD_WORD[31];
               cmd_sh_r  <= CMD_WORD[30:0];
               div_cnt_r <= '0;
               bit_cnt_r <= 5'd0;
            end
            CMD: begin
               if (sck_edge_s) begin
                  div_cnt_r <= '0;
                  spi_sck   <= ~spi_sck;
                  if (spi_sck) begin
                     if (bit_cnt_r == 5'd31) begin
                        state_r   <= DATA;
                        spi_mosi  <= 1'b0;
                        bit_cnt_r <= 5'd0;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        spi_mosi  <= cmd_sh_r[30];
                        cmd_sh_r  <= {cmd_sh_r[29:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + 1'b1;
               end
            end
            DATA: begin
               if (drain_r) begin
                  state_r            <= DONE;
                  spi_ss             <= 1'b1;
                  boot_sequence_done <= 1'b1;
`ifdef KMIE_BOOT_CHECKSUM_EN
                  boot_error         <= (sum_r != chk_r);
`endif
               end else if (sck_edge_s) begin
                  div_cnt_r <= '0;
                  spi_sck   <= ~spi_sck;
                  if (!spi_sck) begin
                     byte_sh_r <= byte_next_s[6:0];
                     bit_cnt_r <= bit_cnt_r + 5'd1;
                     if (bit_cnt_r[2:0] == 3'd7) begin
                        case (bit_cnt_r[4:3])
                           2'd0:    word_r[7:0]   <= byte_next_s;
                           2'd1:    word_r[15:8]  <= byte_next_s;
                           2'd2:    word_r[23:16] <= byte_next_s;
                           default: begin
                              word_cnt_r <= word_cnt_r + 1'b1;
                              if (word_cnt_r == WORD_LAST) begin
                                 last_r <= 1'b1;
                              end
                              // Payload words are written; the trailing checksum word is only kept.
                              if (word_cnt_r < PAY_WORDS) begin
                                 mem_we    <= 1'b1;
                                 mem_wdata <= word_full_s;
`ifdef KMIE_BOOT_CHECKSUM_EN
                                 sum_r     <= sum_r + word_full_s;
                              end else begin
                                 chk_r     <= word_full_s;
`endif
                              end
                           end
                        endcase
                     end
                  end else if (last_r) begin
                     drain_r <= 1'b1;
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + 1'b1;
               end
            end
            DONE: begin
               spi_ss  <= 1'b1;
               spi_sck <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
